// File: rtl/sprite_reg_scan.sv
// Sprite register bank with a lane-parallel point-in-box hit scanner (lowest active index wins).
// Optional macro SPRITE_HIT_COUNT_EN: always scans the full bank and adds a hit_count output.
module sprite_reg_scan #(
    parameter int N_REGS   = 32,
    parameter int REG_W    = 32,
    parameter int AW       = 5,
    parameter int COORD_W  = 10,
    parameter int X_LSB    = 19,
    parameter int Y_LSB    = 9,
    parameter int ACT_BIT  = 29,
    parameter int SPR_SIZE = 20,
    parameter int LANES    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        n_reg,
    input  logic [REG_W-1:0]     data,
    input  logic                 written,
    input  logic [2*COORD_W-1:0] check,
    input  logic                 check_valid,
    output logic                 check_ready,
    output logic [REG_W-1:0]     readData,
    output logic [AW-1:0]        hit_idx,
    output logic                 hit,
    output logic                 done,
    output logic                 success
`ifdef SPRITE_HIT_COUNT_EN
    ,
    output logic [AW:0]          hit_count
`endif
);
    localparam int N_GRP = N_REGS / LANES;
    localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      g_q, g_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic               found_q, found_d;
    logic [AW-1:0]      best_idx_q, best_idx_d;
    logic [REG_W-1:0]   best_data_q, best_data_d;
    logic [REG_W-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]      hidx_q, hidx_d;
    logic               hit_q, hit_d;
    logic               success_q;
    logic [REG_W-1:0]   regs_q [N_REGS];

    logic               wr_ok;
    logic               grp_hit, last_grp, scan_exit;
    logic [AW-1:0]      grp_idx, lane_idx;
`ifdef SPRITE_HIT_COUNT_EN
    logic [AW:0]        grp_cnt, cnt_q, cnt_d, hcnt_q, hcnt_d;
`endif

    // Sums are one bit wider than a coordinate so a box near the maximum cannot wrap to zero.
    function automatic logic in_box(input logic act, input logic [COORD_W-1:0] rx,
                                    input logic [COORD_W-1:0] ry, input logic [COORD_W-1:0] cx,
                                    input logic [COORD_W-1:0] cy);
        logic [COORD_W:0] x0, y0, px, py;
        x0 = {1'b0, rx};
        y0 = {1'b0, ry};
        px = {1'b0, cx};
        py = {1'b0, cy};
        return act && (px >= x0) && (px < x0 + (COORD_W+1)'(SPR_SIZE))
                   && (py >= y0) && (py < y0 + (COORD_W+1)'(SPR_SIZE));
    endfunction

    assign wr_ok = written && (int'(n_reg) < N_REGS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < N_REGS; r++) regs_q[r] <= '0;
            success_q <= 1'b0;
        end else begin
            if (wr_ok) regs_q[n_reg] <= data;
            success_q <= wr_ok;
        end
    end

    // Descending lane order leaves the lowest matching index in grp_idx.
    always_comb begin
        grp_hit  = 1'b0;
        grp_idx  = '0;
        lane_idx = '0;
`ifdef SPRITE_HIT_COUNT_EN
        grp_cnt  = '0;
`endif
        for (int l = LANES - 1; l >= 0; l--) begin
            lane_idx = AW'(int'(g_q) * LANES + l);
            if (in_box(regs_q[lane_idx][ACT_BIT], regs_q[lane_idx][X_LSB +: COORD_W],
                       regs_q[lane_idx][Y_LSB +: COORD_W], cx_q, cy_q)) begin
                grp_hit = 1'b1;
                grp_idx = lane_idx;
`ifdef SPRITE_HIT_COUNT_EN
                grp_cnt = grp_cnt + (AW+1)'(1);
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        found_d     = found_q;
        best_idx_d  = best_idx_q;
        best_data_d = best_data_q;
        rdata_d     = rdata_q;
        hidx_d      = hidx_q;
        hit_d       = hit_q;
        last_grp    = (g_q == GW'(N_GRP - 1));
        scan_exit   = 1'b0;
`ifdef SPRITE_HIT_COUNT_EN
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (check_valid) begin
                    state_d = SCAN;
                    g_d     = '0;
                    cx_d    = check[2*COORD_W-1:COORD_W];
                    cy_d    = check[COORD_W-1:0];
                    found_d = 1'b0;
`ifdef SPRITE_HIT_COUNT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SCAN: begin
                if (grp_hit && !found_q) begin
                    found_d     = 1'b1;
                    best_idx_d  = grp_idx;
                    best_data_d = regs_q[grp_idx];
                end
`ifdef SPRITE_HIT_COUNT_EN
                cnt_d     = cnt_q + grp_cnt;
                scan_exit = last_grp;
`else
                scan_exit = last_grp || grp_hit;
`endif
                if (scan_exit) begin
                    state_d = DONE;
                    hit_d   = found_d;
                    hidx_d  = found_d ? best_idx_d : '0;
                    rdata_d = found_d ? best_data_d : '0;
`ifdef SPRITE_HIT_COUNT_EN
                    hcnt_d  = cnt_d;
`endif
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            g_q         <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            found_q     <= 1'b0;
            best_idx_q  <= '0;
            best_data_q <= '0;
            rdata_q     <= '0;
            hidx_q      <= '0;
            hit_q       <= 1'b0;
`ifdef SPRITE_HIT_COUNT_EN
            cnt_q       <= '0;
            hcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            found_q     <= found_d;
            best_idx_q  <= best_idx_d;
            best_data_q <= best_data_d;
            rdata_q     <= rdata_d;
            hidx_q      <= hidx_d;
            hit_q       <= hit_d;
`ifdef SPRITE_HIT_COUNT_EN
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
`endif
        end
    end

    assign check_ready = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign readData    = rdata_q;
    assign hit_idx     = hidx_q;
    assign hit         = hit_q;
    assign success     = success_q;
`ifdef SPRITE_HIT_COUNT_EN
    assign hit_count   = hcnt_q;
`endif
endmodule

// File: tb/tb_sprite_reg_scan.sv
// Directed bench for sprite_reg_scan: writes, hit/miss queries, latency, box edges, wrap and reset abort.
module tb_sprite_reg_scan;
    localparam int AW      = 5;
    localparam int REG_W   = 32;
    localparam int COORD_W = 10;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [AW-1:0]        n_reg;
    logic [REG_W-1:0]     data;
    logic                 written;
    logic [2*COORD_W-1:0] check;
    logic                 check_valid;
    logic                 check_ready;
    logic [REG_W-1:0]     readData;
    logic [AW-1:0]        hit_idx;
    logic                 hit;
    logic                 done;
    logic                 success;
`ifdef SPRITE_HIT_COUNT_EN
    logic [AW:0]          hit_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    sprite_reg_scan dut (
        .clk(clk), .reset(reset), .n_reg(n_reg), .data(data), .written(written),
        .check(check), .check_valid(check_valid), .check_ready(check_ready),
        .readData(readData), .hit_idx(hit_idx), .hit(hit), .done(done), .success(success)
`ifdef SPRITE_HIT_COUNT_EN
        , .hit_count(hit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_W-1:0] spr(input logic act, input int x, input int y);
        logic [REG_W-1:0] r;
        r = '0;
        r[29]    = act;
        r[28:19] = COORD_W'(x);
        r[18:9]  = COORD_W'(y);
        return r;
    endfunction

    // Hit latency for a first hit in group g (full scan when counting hits).
    function automatic int hit_lat(input int g);
`ifdef SPRITE_HIT_COUNT_EN
        return 9 + 0 * g;
`else
        return 2 + g;
`endif
    endfunction

    task automatic wr_reg(input logic [AW-1:0] i, input logic [REG_W-1:0] d);
        n_reg = i; data = d; written = 1'b1;
        @(posedge clk); #1;
        written = 1'b0;
        chk("success", success, 1);
        @(posedge clk); #1;
        chk("success_pulse", success, 0);
    endtask

    // Handshake in cycle T; lat returns k where done was seen in cycle T+k.
    task automatic query(input int x, input int y, input logic wr, input logic [AW-1:0] wi,
                         input logic [REG_W-1:0] wd, output int lat);
        check = {COORD_W'(x), COORD_W'(y)};
        check_valid = 1'b1;
        written = wr; n_reg = wi; data = wd;
        chk("ready_before_query", check_ready, 1);
        @(posedge clk); #1;
        check_valid = 1'b0;
        written = 1'b0;
        if (wr) chk("success_with_query", success, 1);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_query();
        @(posedge clk); #1;
        chk("done_pulse_low", done, 0);
    endtask

    logic [REG_W-1:0] r5, r2, r3, r9;
    int lat;
    logic seen;

    initial begin
        reset = 1'b1; written = 1'b0; n_reg = '0; data = '0; check = '0; check_valid = 1'b0;
        r5 = spr(1, 100, 50);
        r2 = spr(1, 1020, 0);
        r3 = spr(1, 0, 0);
        r9 = spr(1, 5, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readData", readData, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_hit", hit, 0);
        chk("rst_done", done, 0);
        chk("rst_success", success, 0);
        chk("rst_ready", check_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Inactive sprite at the origin never matches.
        wr_reg(0, spr(0, 0, 0));
        query(5, 5, 0, 0, 0, lat);
        chk("inact_lat", lat, 9);
        chk("inact_hit", hit, 0);
        chk("inact_data", readData, 0);
        chk("inact_idx", hit_idx, 0);
        finish_query();

        wr_reg(5, r5);
        query(110, 60, 0, 0, 0, lat);
        chk("r5_lat", lat, hit_lat(1));
        chk("r5_hit", hit, 1);
        chk("r5_idx", hit_idx, 5);
        chk("r5_data", readData, 64'(r5));
        finish_query();
        chk("r5_hold_hit", hit, 1);

        query(120, 60, 0, 0, 0, lat);
        chk("xedge_lat", lat, 9);
        chk("xedge_hit", hit, 0);
        chk("xedge_data", readData, 0);
        finish_query();

        query(119, 69, 0, 0, 0, lat);
        chk("corner_lat", lat, hit_lat(1));
        chk("corner_hit", hit, 1);
        chk("corner_idx", hit_idx, 5);
        finish_query();

        query(110, 70, 0, 0, 0, lat);
        chk("yedge_hit", hit, 0);
        finish_query();

        // Box at x=1020 must not wrap around to small x.
        wr_reg(2, r2);
        query(1023, 5, 0, 0, 0, lat);
        chk("wrap_in_lat", lat, hit_lat(0));
        chk("wrap_in_hit", hit, 1);
        chk("wrap_in_idx", hit_idx, 2);
        chk("wrap_in_data", readData, 64'(r2));
        finish_query();
        query(3, 5, 0, 0, 0, lat);
        chk("wrap_out_lat", lat, 9);
        chk("wrap_out_hit", hit, 0);
        finish_query();
        query(1019, 5, 0, 0, 0, lat);
        chk("wrap_left_hit", hit, 0);
        finish_query();

        // Reg3 written in the handshake cycle is seen by the scan; lowest index wins over reg9.
        wr_reg(9, r9);
        query(10, 10, 1, 3, r3, lat);
        chk("multi_lat", lat, hit_lat(0));
        chk("multi_hit", hit, 1);
        chk("multi_idx", hit_idx, 3);
        chk("multi_data", readData, 64'(r3));
`ifdef SPRITE_HIT_COUNT_EN
        chk("multi_count", hit_count, 2);
`endif
        finish_query();

        // Reset during a scan aborts it and clears the bank.
        check = {COORD_W'(500), COORD_W'(500)};
        check_valid = 1'b1;
        @(posedge clk); #1;
        check_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", check_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_hit", hit, 0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);
        query(10, 10, 0, 0, 0, lat);
        chk("cleared_lat", lat, 9);
        chk("cleared_hit", hit, 0);
        chk("cleared_idx", hit_idx, 0);
        chk("cleared_data", readData, 0);
        finish_query();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
